flag_file: RTL
==============

Name: flag_file

Overview:
- Parametrised MCU status-flag register file with a LIFO shadow stack for nested interrupts.
- Holds NUM_FLAGS independent flag bits (default C, Z), each with its own load, set and clear controls.
- On interrupt entry the control unit pulses `save` to push the live flags; on return from interrupt it pulses `restore` to pop them.
- Sits between the ALU/control unit and the branch logic.

Parameters:
- NUM_FLAGS, 2, number of flag bits; must be >= 1.
- SHADOW_DEPTH, 4, number of shadow-stack entries (maximum interrupt nesting); must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flg_ld  in  NUM_FLAGS  per-flag load enable; loads flg_d[i].
- flg_set  in  NUM_FLAGS  per-flag set to 1.
- flg_clr  in  NUM_FLAGS  per-flag clear to 0.
- flg_d  in  NUM_FLAGS  per-flag load data (from the ALU).
- save  in  1  push the live flags onto the shadow stack (interrupt entry).
- restore  in  1  pop the top entry into the live flags (RETI).
- err_clr  in  1  clears the sticky error bits.
- flags_q  out  NUM_FLAGS  live flag values.
- depth  out  $clog2(SHADOW_DEPTH+1)  number of valid shadow entries.
- shadow_empty  out  1  depth == 0.
- shadow_full  out  1  depth == SHADOW_DEPTH.
- ovf_err  out  1  sticky: save was attempted while full.
- unf_err  out  1  sticky: restore was attempted while empty.

Behaviour:
- All state updates on posedge clk. No asynchronous paths.
- Reset: flags_q = 0, depth = 0, ovf_err = 0, unf_err = 0, shadow_empty = 1, shadow_full = 0. Shadow contents are don't-care.
- Reset in the middle of a nesting sequence discards all shadow entries.
- Per-flag next-state priority, highest first:
  1. rst
  2. valid restore: flag takes the top shadow entry bit
  3. flg_clr[i]
  4. flg_set[i]
  5. flg_ld[i]
  6. hold
- A valid restore overrides all per-flag ops in that cycle.
- Save (restore = 0):
  - Not full: entry[depth] <= flags_q as registered before this edge (pre-update value); depth+1.
  - Per-flag ops in the same cycle still update the live flags, so the pushed value differs from the next flags_q.
  - Full: push dropped, depth unchanged, ovf_err <= 1, per-flag ops still apply.
- Restore (save = 0):
  - Not empty: flags_q <= entry[depth-1]; depth-1.
  - Empty: no pop, unf_err <= 1, per-flag ops apply normally.
- Save and restore in the same cycle:
  - depth > 0: swap. flags_q <= top entry; top entry <= pre-update flags_q; depth unchanged; no error.
  - depth == 0: behaves as save only; unf_err <= 1.
- Latency: one cycle for every op. flags_q, depth and the status outputs are all registered, or decoded only from registered depth.
- Sticky errors:
  - Cleared by err_clr the cycle after assertion.
  - A new error event in the same cycle as err_clr takes precedence and leaves the bit at 1.
- depth never exceeds SHADOW_DEPTH and never wraps below 0.

Decomposition:
- Package `flag_pkg`:
  - Flag index constants FLAG_C = 0, FLAG_Z = 1.
  - Default NUM_FLAGS and SHADOW_DEPTH.
  - A `flag_vec_t` typedef for the default width.
- Sub-module `shadow_stack`:
  - Parametrised LIFO (WIDTH, DEPTH) with push, pop, swap, top, depth, full and empty.
  - Owns the overflow/underflow detection.
- flag_file owns the per-flag priority logic and the sticky error bits.

Test Plan:
- Reset, then flg_set = 2'b11, flg_clr = 2'b01 in the same cycle -> flags_q = 2'b10 (clear beats set on C).
- flags_q = 2'b01, save with flg_ld = 2'b11, flg_d = 2'b10 -> flags_q = 2'b10, depth = 1; then restore -> flags_q = 2'b01, depth = 0.
- Four saves with distinct values 01, 10, 11, 00, then a fifth save -> depth stays 4, shadow_full = 1, ovf_err = 1. Four restores return 00, 11, 10, 01 in order.
- Restore at depth 0 with flg_set = 2'b01 -> unf_err = 1, flags_q[0] = 1, depth = 0. err_clr -> unf_err = 0 next cycle.
- depth = 2, top entry 2'b11, flags_q = 2'b00; save + restore together -> flags_q = 2'b11, top entry = 2'b00, depth = 2.
- depth = 3; assert rst -> depth = 0, flags_q = 0, errors = 0; a following restore sets unf_err = 1.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants and types for the status-flag register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flag_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;

    localparam int NUM_FLAGS_DEF    = 2;
    localparam int SHADOW_DEPTH_DEF = 4;

    typedef logic [NUM_FLAGS_DEF-1:0] flag_vec_t;

endpackage

// File: rtl/shadow_stack.sv
// LIFO shadow stack with push, pop and a same-cycle swap of the top entry.
// Latency: one cycle for every operation; top is read from registered state.
// Backpressure: none; a push while full or pop while empty is dropped and flagged.
module shadow_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic                       pop_ok,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    cnt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DW'(DEPTH));
    assign depth   = cnt;
    assign top_idx = AW'(cnt - DW'(1));
    assign wr_idx  = AW'(cnt);
    assign top     = mem[top_idx];
    assign pop_ok  = do_pop | do_swap;

    // Push+pop on an empty stack degrades to a plain push plus an underflow.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_swap = 1'b0;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (push && pop) begin
            if (empty) begin
                do_push = 1'b1;
                unf     = 1'b1;
            end else begin
                do_swap = 1'b1;
            end
        end else if (push) begin
            if (full) ovf = 1'b1;
            else      do_push = 1'b1;
        end else if (pop) begin
            if (empty) unf = 1'b1;
            else       do_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + DW'(1);
        end else if (do_pop) begin
            cnt <= cnt - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end else if (do_swap) begin
            mem[top_idx] <= din;
        end
    end

endmodule

// File: rtl/flag_file.sv
// Status-flag register file with per-flag load/set/clear and an interrupt shadow stack.
// Latency: one cycle for every op; all outputs registered or decoded from registered depth.
// Backpressure: none; overflow/underflow attempts are dropped and latched in sticky errors.
module flag_file
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS    = NUM_FLAGS_DEF,
    parameter int SHADOW_DEPTH = SHADOW_DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_FLAGS-1:0]              flg_ld,
    input  logic [NUM_FLAGS-1:0]              flg_set,
    input  logic [NUM_FLAGS-1:0]              flg_clr,
    input  logic [NUM_FLAGS-1:0]              flg_d,
    input  logic                              save,
    input  logic                              restore,
    input  logic                              err_clr,
    output logic [NUM_FLAGS-1:0]              flags_q,
    output logic [$clog2(SHADOW_DEPTH+1)-1:0] depth,
    output logic                              shadow_empty,
    output logic                              shadow_full,
    output logic                              ovf_err,
    output logic                              unf_err
);

    logic [NUM_FLAGS-1:0] flags_nxt;
    logic [NUM_FLAGS-1:0] stk_top;
    logic                 pop_ok;
    logic                 ovf_ev;
    logic                 unf_ev;

    // The stack always pushes the pre-update flags, independent of same-cycle flag ops.
    shadow_stack #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (SHADOW_DEPTH)
    ) u_stack (
        .clk    (clk),
        .clr    (rst),
        .push   (save),
        .pop    (restore),
        .din    (flags_q),
        .top    (stk_top),
        .pop_ok (pop_ok),
        .depth  (depth),
        .full   (shadow_full),
        .empty  (shadow_empty),
        .ovf    (ovf_ev),
        .unf    (unf_ev)
    );

    always_comb begin
        flags_nxt = flags_q;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (pop_ok)          flags_nxt[i] = stk_top[i];
            else if (flg_clr[i]) flags_nxt[i] = 1'b0;
            else if (flg_set[i]) flags_nxt[i] = 1'b1;
            else if (flg_ld[i])  flags_nxt[i] = flg_d[i];
        end
    end

    // A fresh error event wins over a same-cycle err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            ovf_err <= ovf_ev | (ovf_err & ~err_clr);
            unf_err <= unf_ev | (unf_err & ~err_clr);
        end
    end

endmodule
